// File: rtl/ofb_chain_ctrl.sv
// ----------------------------------------------------------------------------
// ofb_chain_ctrl
// Sequencer for a combinational AES-128 OFB core. It accepts one 128-bit
// block at a time, waits CORE_LAT cycles for the core, returns the result,
// and chains the keystream (core_pre_enc) into the next block's IV.
//
// Optional feature macro: OFB_CHAIN_CNT_EN
//   When defined, the blk_count output and its counter exist.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : begin a message (IDLE only) / return to IDLE
//   key, iv           : AES key and initial vector, sampled on start
//   in_valid/in_ready/in_data/in_last     : input block stream
//   out_valid/out_ready/out_data/out_last : result stream
//   core_key/core_iv/core_image           : registered drives to the core
//   core_ciphertext/core_pre_enc          : core results
//   busy              : high whenever the controller is not idle
//   blk_count         : delivered block count (OFB_CHAIN_CNT_EN only)
// ----------------------------------------------------------------------------
module ofb_chain_ctrl #(
   parameter int unsigned CORE_LAT = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [127:0] key,
   input  logic [127:0] iv,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_last,
   output logic [127:0] core_key,
   output logic [127:0] core_iv,
   output logic [127:0] core_image,
   input  logic [127:0] core_ciphertext,
   input  logic [127:0] core_pre_enc,
   output logic         busy
`ifdef OFB_CHAIN_CNT_EN
   ,
   output logic [CNT_W-1:0] blk_count
`endif
);

   localparam int unsigned BLK_W = 128;
   localparam int unsigned LAT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_WAIT   = 2'd2,
      S_OUT    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LAT_W-1:0] r_wait_cnt;
   logic [BLK_W-1:0] r_chain;
   logic             r_last;
   logic             w_do_start;
   logic             w_do_accept;
   logic             w_do_capture;
   logic             w_do_deliver;

   // Elaboration-time guard on parameter ranges.
   if (CORE_LAT < 1 || CORE_LAT > 15 || CNT_W < 1) begin : g_bad_param
      $error("ofb_chain_ctrl: CORE_LAT must be 1..15 and CNT_W >= 1");
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath strobes; abort overrides every transition.
   always_comb begin
      w_state_nxt  = r_state;
      w_do_start   = 1'b0;
      w_do_accept  = 1'b0;
      w_do_capture = 1'b0;
      w_do_deliver = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_ACCEPT;
               w_do_start  = 1'b1;
            end
         end
         S_ACCEPT: begin
            if (in_valid && in_ready) begin
               w_state_nxt = S_WAIT;
               w_do_accept = 1'b1;
            end
         end
         S_WAIT: begin
            // Counter reaches zero CORE_LAT edges after accept; capture on the next.
            if (r_wait_cnt == LAT_W'(0)) begin
               w_state_nxt  = S_OUT;
               w_do_capture = 1'b1;
            end
         end
         S_OUT: begin
            if (out_valid && out_ready) begin
               w_state_nxt  = out_last ? S_IDLE : S_ACCEPT;
               w_do_deliver = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (abort) begin
         w_state_nxt  = S_IDLE;
         w_do_start   = 1'b0;
         w_do_accept  = 1'b0;
         w_do_capture = 1'b0;
         w_do_deliver = 1'b0;
      end
   end

   // Registered handshake/status outputs, core drives and chaining datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         core_key   <= '0;
         core_iv    <= '0;
         core_image <= '0;
         r_chain    <= '0;
         r_last     <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         in_ready  <= (w_state_nxt == S_ACCEPT);
         out_valid <= (w_state_nxt == S_OUT);
         busy      <= (w_state_nxt != S_IDLE);
         if (w_do_start) begin
            core_key <= key;
            r_chain  <= iv;
         end
         if (w_do_accept) begin
            core_image <= in_data;
            r_last     <= in_last;
            core_iv    <= r_chain;
            r_wait_cnt <= LAT_W'(CORE_LAT);
         end else if (r_state == S_WAIT && r_wait_cnt != LAT_W'(0)) begin
            r_wait_cnt <= r_wait_cnt - LAT_W'(1);
         end
         if (w_do_capture) begin
            out_data <= core_ciphertext;
            r_chain  <= core_pre_enc;
            out_last <= r_last;
         end
      end
   end

`ifdef OFB_CHAIN_CNT_EN
   // Delivered-block counter; cleared on start, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_count <= '0;
      end else if (w_do_start) begin
         blk_count <= '0;
      end else if (w_do_deliver) begin
         blk_count <= blk_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ofb_chain_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ofb_chain_ctrl
// Bench for ofb_chain_ctrl. Supplies a stand-in OFB core (known AES-128 OFB
// keystream blocks for the reference key/IV chain, a mixing function
// otherwise), a transaction-level model of the controller, a per-cycle
// compare process, directed checks with literal expectations, and a
// randomized phase. Honors OFB_CHAIN_CNT_EN for the blk_count port.
// ----------------------------------------------------------------------------
module tb_ofb_chain_ctrl;

   localparam int unsigned TB_LAT   = 1;
   localparam int unsigned TB_CNT_W = 2;

   localparam logic [127:0] NK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] NIV  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] OFB1 = 128'h50fe67cc996d32b6da0937e99bafec60;
   localparam logic [127:0] OFB2 = 128'hd9a4dada0892239f6b8b3d7680e15674;
   localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] C1   = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
   localparam logic [127:0] C2   = 128'h7789508d16918f03f53c52dac54ed825;

   logic         clk = 1'b0;
   logic         rst, start, abort;
   logic [127:0] key, iv;
   logic         in_valid, in_ready, in_last;
   logic [127:0] in_data;
   logic         out_valid, out_ready, out_last;
   logic [127:0] out_data;
   logic [127:0] core_key, core_iv, core_image, core_ciphertext, core_pre_enc;
   logic         busy;
`ifdef OFB_CHAIN_CNT_EN
   logic [TB_CNT_W-1:0] blk_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   ofb_chain_ctrl #(.CORE_LAT(TB_LAT), .CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .key(key), .iv(iv),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .core_key(core_key), .core_iv(core_iv), .core_image(core_image),
      .core_ciphertext(core_ciphertext), .core_pre_enc(core_pre_enc),
      .busy(busy)
`ifdef OFB_CHAIN_CNT_EN
      , .blk_count(blk_count)
`endif
   );

   // Stand-in keystream: real AES-OFB blocks for the reference chain.
   function automatic logic [127:0] ks_fn(input logic [127:0] k, input logic [127:0] v);
      logic [127:0] x;
      if (k == NK && v == NIV)  return OFB1;
      if (k == NK && v == OFB1) return OFB2;
      x = k ^ {v[63:0], v[127:64]};
      return ({x[100:0], x[127:101]} + x) ^ 128'hc3a5_5a3c_0f1e_e1f0_9669_6996_1234_5678;
   endfunction

   assign core_pre_enc    = ks_fn(core_key, core_iv);
   assign core_ciphertext = core_image ^ core_pre_enc;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Transaction-level model: message open / waiting for input / block due at
   // a given edge / result pending.
   longint       edge_n = 0;
   longint       m_due  = 0;
   bit           m_open, m_in_rdy, m_wait, m_ov, m_ol, m_lastp;
   logic [127:0] m_key, m_chain, m_iv, m_img, m_od, m_ks;
   int           m_cnt;

   always @(posedge clk) begin
      edge_n++;
      if (rst) begin
         m_open = 0; m_in_rdy = 0; m_wait = 0; m_ov = 0; m_ol = 0; m_lastp = 0;
         m_key = '0; m_chain = '0; m_iv = '0; m_img = '0; m_od = '0; m_cnt = 0;
      end else if (abort) begin
         m_open = 0; m_in_rdy = 0; m_wait = 0; m_ov = 0;
      end else if (!m_open) begin
         if (start) begin
            m_open = 1; m_in_rdy = 1; m_key = key; m_chain = iv; m_cnt = 0;
         end
      end else if (m_in_rdy) begin
         if (in_valid) begin
            m_in_rdy = 0; m_wait = 1; m_img = in_data; m_lastp = in_last;
            m_iv = m_chain; m_due = edge_n + TB_LAT + 1;
         end
      end else if (m_wait) begin
         if (edge_n == m_due) begin
            m_ks = ks_fn(m_key, m_iv);
            m_wait = 0; m_ov = 1; m_od = m_img ^ m_ks; m_chain = m_ks; m_ol = m_lastp;
         end
      end else if (m_ov) begin
         if (out_ready) begin
            m_ov = 0;
            m_cnt = (m_cnt + 1) % (1 << TB_CNT_W);
            if (m_ol) m_open = 0;
            else      m_in_rdy = 1;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_in_ready", 128'(in_ready), 128'(m_in_rdy));
         chk("m_out_valid", 128'(out_valid), 128'(m_ov));
         chk("m_busy", 128'(busy), 128'(m_open));
         chk("m_core_key", core_key, m_key);
         chk("m_core_iv", core_iv, m_iv);
         chk("m_core_image", core_image, m_img);
         if (m_ov) begin
            chk("m_out_data", out_data, m_od);
            chk("m_out_last", 128'(out_last), 128'(m_ol));
         end
`ifdef OFB_CHAIN_CNT_EN
         chk("m_blk_count", 128'(blk_count), 128'(m_cnt));
`endif
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   int wrap_exp[5] = '{1, 2, 3, 0, 1};

   initial begin
      rst = 1; start = 0; abort = 0; key = '0; iv = '0;
      in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
      step();
      chk_en = 1;
      step();
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_data", out_data, 128'(0));
      chk("rst_core_key", core_key, 128'(0));

      // Reference vector, first block.
      rst = 0; key = NK; iv = NIV; start = 1;
      step(); start = 0;
      chk("start_busy", 128'(busy), 128'(1));
      chk("start_in_ready", 128'(in_ready), 128'(1));
      chk("start_core_key", core_key, NK);
      in_valid = 1; in_data = P1; in_last = 0;
      step(); in_valid = 0;
      chk("acc1_in_ready", 128'(in_ready), 128'(0));
      chk("acc1_core_iv", core_iv, NIV);
      step();
      chk("ov_after_1edge", 128'(out_valid), 128'(0));
      step();
      chk("ov_after_2edge", 128'(out_valid), 128'(1));
      chk("blk1_out_data", out_data, C1);
      chk("blk1_out_last", 128'(out_last), 128'(0));
      repeat (5) begin
         step();
         chk("hold_out_data", out_data, C1);
         chk("hold_in_ready", 128'(in_ready), 128'(0));
         chk("hold_out_valid", 128'(out_valid), 128'(1));
      end
      out_ready = 1;
      step(); out_ready = 0;
      chk("hs1_out_valid", 128'(out_valid), 128'(0));
      chk("hs1_in_ready", 128'(in_ready), 128'(1));

      // Second block chains the captured keystream.
      in_valid = 1; in_data = P2; in_last = 1;
      step(); in_valid = 0; in_last = 0;
      chk("acc2_core_iv", core_iv, OFB1);
      step(); step();
      chk("blk2_out_data", out_data, C2);
      chk("blk2_out_last", 128'(out_last), 128'(1));
      out_ready = 1;
      step(); out_ready = 0;
      chk("blk2_idle", 128'(busy), 128'(0));
`ifdef OFB_CHAIN_CNT_EN
      chk("blk2_count", 128'(blk_count), 128'(2));
`endif

      // Abort together with start while waiting on the core.
      start = 1;
      step(); start = 0;
      in_valid = 1; in_data = P1;
      step(); in_valid = 0;
      abort = 1; start = 1;
      step(); abort = 0; start = 0;
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_out_valid", 128'(out_valid), 128'(0));
      repeat (3) begin
         step();
         chk("abort_no_out", 128'(out_valid), 128'(0));
      end
      start = 1;
      step(); start = 0;
      chk("restart_in_ready", 128'(in_ready), 128'(1));

      // Reset while a result is pending.
      in_valid = 1; in_data = P1;
      step(); in_valid = 0;
      step(); step();
      chk("pre_rst_out_data", out_data, C1);
      rst = 1;
      step(); rst = 0;
      chk("rst_out_valid2", 128'(out_valid), 128'(0));
      chk("rst_out_data2", out_data, 128'(0));
      chk("rst_core_iv2", core_iv, 128'(0));
      chk("rst_core_image2", core_image, 128'(0));
      chk("rst_out_last2", 128'(out_last), 128'(0));

      // Five-block message: counter wraps at CNT_W=2.
      key = NK; iv = NIV; start = 1;
      step(); start = 0;
      for (int b = 0; b < 5; b++) begin
         in_valid = 1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_last = (b == 4);
         step(); in_valid = 0; in_last = 0;
         step(); step();
         out_ready = 1;
         step(); out_ready = 0;
`ifdef OFB_CHAIN_CNT_EN
         chk("wrap_count", 128'(blk_count), 128'(wrap_exp[b]));
`else
         chk("wrap_busy", 128'(busy), 128'(b != 4));
`endif
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(99) == 0);
         abort     = ($urandom_range(49) == 0);
         start     = ($urandom_range(7) == 0);
         key       = {$urandom, $urandom, $urandom, $urandom};
         iv        = {$urandom, $urandom, $urandom, $urandom};
         in_valid  = ($urandom_range(1) == 1);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         in_last   = ($urandom_range(3) == 0);
         out_ready = ($urandom_range(1) == 1);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ofb_chain_ctrl.md
OFB_CHAIN_CTRL -- requirements
Module: ofb_chain_ctrl

Interface
REQ-001 SHALL have parameter CORE_LAT, default 1, cycles between driving core inputs and sampling core outputs (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 16, width of the block counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, single-cycle pulse that begins a message.
REQ-006 SHALL have port abort, input, 1, synchronous return to IDLE.
REQ-007 SHALL have port key, input, 128, AES-128 key, sampled on start.
REQ-008 SHALL have port iv, input, 128, initial vector, sampled on start.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 128) and in_last (input, 1), the input block stream.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 128) and out_last (output, 1), the result stream.
REQ-011 SHALL have ports core_key, core_iv and core_image, each output, 128, registered drives to the combinational OFB core.
REQ-012 SHALL have ports core_ciphertext and core_pre_enc, each input, 128, OFB core results (data XOR keystream, and keystream).
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-014 SHALL have port blk_count, output, CNT_W, count of delivered blocks (present only per REQ-030).

Function
REQ-015 SHALL implement states IDLE, ACCEPT, WAIT and OUT.
REQ-016 IDLE: in_ready=0 and out_valid=0; on start, SHALL latch key into core_key and iv into the chaining register, clear blk_count, and go to ACCEPT.
REQ-017 ACCEPT: in_ready=1; on in_valid&in_ready, SHALL latch in_data into core_image and in_last into last_r, drive core_iv from the chaining register, load the wait counter with CORE_LAT, and go to WAIT.
REQ-018 WAIT: in_ready=0; after exactly CORE_LAT cycles in WAIT, SHALL capture core_ciphertext into out_data and core_pre_enc into the chaining register, set out_last=last_r, and go to OUT.
REQ-019 out_valid SHALL rise in the cycle CORE_LAT+1 edges after the accepting edge.
REQ-020 OUT: out_valid=1; out_data and out_last SHALL be held stable until out_ready=1.
REQ-021 On out_valid&out_ready, SHALL deassert out_valid and increment blk_count; next state SHALL be IDLE if out_last=1, else ACCEPT.
REQ-022 Next block keystream SHALL be the previous core_pre_enc (OFB chaining); the chaining register SHALL change only in WAIT capture and start.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 abort SHALL force IDLE and clear out_valid next edge from any state, overriding start and every other transition; the chaining register and blk_count SHALL be retained.
REQ-025 blk_count SHALL wrap from 2^CNT_W-1 to 0 without error.
REQ-026 At most one block SHALL be in flight; in_ready and out_valid SHALL never be high together.

Reset
REQ-027 rst=1 at a clock edge SHALL set state IDLE; in_ready, out_valid, out_last, busy=0; out_data, core_key, core_iv, core_image, chaining register, blk_count=0.
REQ-028 rst SHALL override abort and start; rst mid-operation SHALL discard the in-flight block with no output.

Configuration
REQ-029 Macro OFB_CHAIN_CNT_EN SHALL select the block counter feature.
REQ-030 With OFB_CHAIN_CNT_EN defined, the blk_count port and counter SHALL exist; without it, neither port nor counter logic SHALL exist and all other behaviour SHALL be identical.

Verification (real OFB core attached, CORE_LAT=1)
REQ-031 key=2b7e151628aed2a6abf7158809cf4f3c, iv=000102030405060708090a0b0c0d0e0f, start, block 6bc1bee22e409f96e93d7e117393172a -> out_data=3b3fd92eb72dad20333449f8e83cfb4a, core_pre_enc captured=50fe67cc996d32b6da0937e99bafec60, out_valid 2 edges after accept.
REQ-032 Continue with second block ae2d8a571e03ac9c9eb76fac45af8e51 (in_last=1) -> out_data=7789508d16918f03f53c52dac54ed825, out_last=1, state IDLE after handshake, blk_count=2.
REQ-033 out_ready held low 5 cycles in OUT -> out_data stable and in_ready=0 throughout; handshake on cycle 6 -> ACCEPT.
REQ-034 abort asserted in WAIT together with start -> IDLE next edge, out_valid=0, no output produced; new start then accepted.
REQ-035 rst pulsed in OUT -> all outputs zero next edge; CNT_W=2 run of 5 blocks -> blk_count sequence 1,2,3,0,1.
